// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, captures code words into an
// instruction register and hands them to decode over valid/ready.
module fetch_sequencer #(
  parameter int         ADDR_W  = 6,
  parameter int         CODE_W  = 23,
  parameter logic [2:0] HALT_OP = 3'b111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [CODE_W-1:0] im_code,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [CODE_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  function automatic logic [2:0] opcode_of(input logic [CODE_W-1:0] code);
    return code[16:14];
  endfunction

  state_t              state_r, state_n;
  logic [ADDR_W-1:0]   pc_r, pc_n;
  logic                ir_valid_r, ir_valid_n;
  logic [CODE_W-1:0]   ir_data_r, ir_data_n;
  logic [ADDR_W-1:0]   ir_pc_r, ir_pc_n;
  logic                busy_r, halted_r;
  logic                slot_free_s, xfer_s;

  assign slot_free_s = !ir_valid_r || ir_ready;
  assign xfer_s      = ir_valid_r && ir_ready;

  // Next-state, PC and instruction-register update rules.
  always_comb begin
    state_n    = state_r;
    pc_n       = pc_r;
    ir_valid_n = ir_valid_r;
    ir_data_n  = ir_data_r;
    ir_pc_n    = ir_pc_r;
    case (state_r)
      IDLE: begin
        // start and redirect may coincide; both take effect.
        if (redirect_valid) pc_n = redirect_addr;
        else                pc_n = pc_r;
        if (start) state_n = FETCH;
        else       state_n = IDLE;
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_n       = redirect_addr;
          ir_valid_n = 1'b0;
        end else if (slot_free_s) begin
          ir_data_n  = im_code;
          ir_pc_n    = pc_r;
          ir_valid_n = 1'b1;
          // The halt word is delivered but the PC parks on it.
          if (opcode_of(im_code) == HALT_OP) state_n = HALT;
          else                               pc_n    = pc_r + PC_ONE;
        end else begin
          ir_valid_n = ir_valid_r;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_n       = redirect_addr;
          ir_valid_n = 1'b0;
          state_n    = FETCH;
        end else if (xfer_s) begin
          ir_valid_n = 1'b0;
        end else begin
          ir_valid_n = ir_valid_r;
        end
      end
      default: begin
        state_n    = IDLE;
        ir_valid_n = 1'b0;
      end
    endcase
  end

  // State, PC, instruction register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pc_r       <= {ADDR_W{1'b0}};
      ir_valid_r <= 1'b0;
      ir_data_r  <= {CODE_W{1'b0}};
      ir_pc_r    <= {ADDR_W{1'b0}};
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_n;
      pc_r       <= pc_n;
      ir_valid_r <= ir_valid_n;
      ir_data_r  <= ir_data_n;
      ir_pc_r    <= ir_pc_n;
      busy_r     <= (state_n == FETCH);
      halted_r   <= (state_n == HALT);
    end
  end

  assign im_addr  = pc_r;
  assign ir_valid = ir_valid_r;
  assign ir_data  = ir_data_r;
  assign ir_pc    = ir_pc_r;
  assign busy     = busy_r;
  assign halted   = halted_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed plan steps plus random traffic checked
// cycle by cycle against a behavioural fetch/delivery model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, redirect_valid, ir_ready;
  logic [5:0]  redirect_addr;
  logic [5:0]  im_addr, ir_pc;
  logic [22:0] im_code, ir_data;
  logic        ir_valid, busy, halted;

  logic        h_start, h_redirect_valid, h_ir_ready;
  logic [5:0]  h_redirect_addr;
  logic [5:0]  h_im_addr, h_ir_pc;
  logic [22:0] h_im_code, h_ir_data;
  logic        h_ir_valid, h_busy, h_halted;

  logic [22:0] mem [64];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign im_code   = mem[im_addr];
  assign h_im_code = mem[h_im_addr];

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .im_addr(im_addr), .im_code(im_code),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
    .busy(busy), .halted(halted)
  );

  fetch_sequencer #(.HALT_OP(3'b000)) dut_h (
    .clk(clk), .rst_n(rst_n), .start(h_start),
    .redirect_valid(h_redirect_valid), .redirect_addr(h_redirect_addr),
    .im_addr(h_im_addr), .im_code(h_im_code),
    .ir_valid(h_ir_valid), .ir_ready(h_ir_ready), .ir_data(h_ir_data), .ir_pc(h_ir_pc),
    .busy(h_busy), .halted(h_halted)
  );

  // Reference model of the main instance: mode, PC, and the held instruction.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;
  int          m_mode;
  int          m_pc;
  bit          m_v;
  logic [22:0] m_d;
  int          m_ipc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_v = 1'b0; m_d = 23'h0; m_ipc = 0;
  endtask

  task automatic model_step();
    bit          free, xfer;
    logic [22:0] code;
    free = !m_v || ir_ready;
    xfer = m_v && ir_ready;
    code = mem[m_pc];
    if (m_mode == M_IDLE) begin
      if (redirect_valid) m_pc = int'(redirect_addr);
      if (start) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (redirect_valid) begin
        m_pc = int'(redirect_addr); m_v = 1'b0;
      end else if (free) begin
        m_d = code; m_ipc = m_pc; m_v = 1'b1;
        if (code[16:14] == 3'b111) m_mode = M_HALTED;
        else m_pc = (m_pc + 1) % 64;
      end
    end else begin
      if (redirect_valid) begin
        m_pc = int'(redirect_addr); m_v = 1'b0; m_mode = M_RUN;
      end else if (xfer) m_v = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("im_addr",  32'(im_addr),  32'(m_pc));
    chk("ir_valid", 32'(ir_valid), 32'(m_v));
    chk("ir_data",  32'(ir_data),  32'(m_d));
    chk("ir_pc",    32'(ir_pc),    32'(m_ipc));
    chk("busy",     32'(busy),     32'(m_mode == M_RUN));
    chk("halted",   32'(halted),   32'(m_mode == M_HALTED));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  // Called 1 time unit after a rising edge: reset is seen without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("h_ir_valid_rst", 32'(h_ir_valid), 32'd0);
    chk("h_im_addr_rst",  32'(h_im_addr),  32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [22:0] plan [6];
    plan[0] = 23'h000000; plan[1] = 23'h000001; plan[2] = 23'h000002;
    plan[3] = 23'h000020; plan[4] = 23'h000050; plan[5] = 23'h000000;
    for (int a = 0; a < 64; a++) mem[a] = 23'h0;
    for (int a = 0; a < 5; a++) mem[a] = plan[a];

    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = 6'd0; ir_ready = 1'b1;
    h_start = 1'b0; h_redirect_valid = 1'b0; h_redirect_addr = 6'd0; h_ir_ready = 1'b1;
    #2;
    model_reset();
    check_model();
    chk("busy_rst",   32'(busy),   32'd0);
    chk("halted_rst", 32'(halted), 32'd0);
    #10;
    rst_n = 1'b1;

    // Straight-line program, ready held high.
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int i = 0; i < 6; i++) begin
      chk("seq_data", 32'(ir_data), 32'(plan[i]));
      chk("seq_pc",   32'(ir_pc),   32'(i));
      chk("seq_vld",  32'(ir_valid), 32'd1);
      tick();
    end

    // Back-pressure while ir_pc=2.
    do_reset();
    start = 1'b1; tick(); start = 1'b0; tick(); tick(); tick();
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_data", 32'(ir_data), 32'h000002);
      chk("stall_pc",   32'(ir_pc),   32'd2);
      chk("stall_addr", 32'(im_addr), 32'd3);
      if (i < 2) tick();
    end
    ir_ready = 1'b1;
    tick();
    chk("release_data", 32'(ir_data), 32'h000020);
    chk("release_pc",   32'(ir_pc),   32'd3);

    // PC wrap.
    for (int i = 0; i < 60; i++) tick();
    chk("wrap_pc63",   32'(ir_pc),   32'd63);
    chk("wrap_addr0",  32'(im_addr), 32'd0);
    tick();
    chk("wrap_pc0",    32'(ir_pc),   32'd0);
    chk("wrap_addr1",  32'(im_addr), 32'd1);

    // Redirect flush during a transfer.
    redirect_valid = 1'b1; redirect_addr = 6'd4; tick(); redirect_valid = 1'b0;
    chk("redir_flush", 32'(ir_valid), 32'd0);
    tick();
    chk("redir_vld",  32'(ir_valid), 32'd1);
    chk("redir_data", 32'(ir_data),  32'h000050);
    chk("redir_pc",   32'(ir_pc),    32'd4);

    // Redirect and start together in IDLE.
    do_reset();
    start = 1'b1; redirect_valid = 1'b1; redirect_addr = 6'd3; tick();
    start = 1'b0; redirect_valid = 1'b0; tick();
    chk("idle_redir_pc",   32'(ir_pc),   32'd3);
    chk("idle_redir_data", 32'(ir_data), 32'h000020);

    // Async reset mid-stream, then nothing until start.
    tick();
    chk("pre_rst_vld", 32'(ir_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_vld",  32'(ir_valid), 32'd0);
      chk("post_rst_addr", 32'(im_addr),  32'd0);
    end

    // Halting instance (HALT_OP=000: every word here halts).
    h_start = 1'b1; tick(); h_start = 1'b0; tick();
    chk("h_vld",    32'(h_ir_valid), 32'd1);
    chk("h_pc",     32'(h_ir_pc),    32'd0);
    chk("h_halted", 32'(h_halted),   32'd1);
    chk("h_busy",   32'(h_busy),     32'd0);
    chk("h_addr",   32'(h_im_addr),  32'd0);
    tick();
    chk("h_drained", 32'(h_ir_valid), 32'd0);
    h_start = 1'b1; tick(); h_start = 1'b0; tick();
    chk("h_start_ign_halted", 32'(h_halted),   32'd1);
    chk("h_start_ign_busy",   32'(h_busy),     32'd0);
    chk("h_start_ign_vld",    32'(h_ir_valid), 32'd0);
    chk("h_start_ign_addr",   32'(h_im_addr),  32'd0);
    h_redirect_valid = 1'b1; h_redirect_addr = 6'd2; tick(); h_redirect_valid = 1'b0;
    chk("h_resume_busy", 32'(h_busy),    32'd1);
    chk("h_resume_addr", 32'(h_im_addr), 32'd2);
    tick();
    chk("h_resume_vld", 32'(h_ir_valid), 32'd1);
    chk("h_resume_pc",  32'(h_ir_pc),    32'd2);

    // Random program and traffic against the model.
    for (int a = 0; a < 64; a++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      mem[a] = {6'd0, op, 4'($urandom), 10'($urandom)};
    end
    do_reset();
    for (int c = 0; c < 600; c++) begin
      start          = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_addr  = 6'($urandom);
      ir_ready       = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
